// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: sequencer for the shared iterative RV32M multiply/divide unit
module muldiv_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic                spec_q, spec_d;
  logic                is_div, s1, s2, neg1, neg2, div0, ovf;
  logic [XLEN-1:0]     mag1, mag2, spec_val;
  logic [XLEN:0]       mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0]   mul_nxt, div_nxt, prod;
  logic [XLEN-1:0]     quo, rem, res;
  // operand decode: signedness, magnitudes and the single-cycle special cases
  always_comb begin
    is_div   = funct3[2];
    s1       = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    s2       = is_div ? ~funct3[0] : ~funct3[1];
    neg1     = s1 & rs1_data[XLEN-1];
    neg2     = s2 & rs2_data[XLEN-1];
    mag1     = neg1 ? -rs1_data : rs1_data;
    mag2     = neg2 ? -rs2_data : rs2_data;
    div0     = is_div & (rs2_data == '0);
    ovf      = is_div & ~funct3[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_data == '1);
    spec_val = div0 ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  end
  // one radix-2 step: shift-add multiply and restoring divide on {hi, lo}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    mul_nxt  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    div_nxt  = {div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0], acc_q[XLEN-2:0], ~div_diff[XLEN]};
  end
  // final sign fix and result selection, only visible in DONE
  always_comb begin
    prod      = neg_q ? -acc_q : acc_q;
    quo       = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem       = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    res       = spec_q ? acc_q[XLEN-1:0] :
                op_q[2] ? (op_q[1] ? rem : quo) :
                (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    out_valid = (state_q == DONE);
    result    = out_valid ? res : '0;
    stall     = in_valid & ~out_valid & ~flush;
  end
  // next-state logic: accept in IDLE, iterate in BUSY, flush wins everywhere
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    spec_d  = spec_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d    = funct3;
        neg_d   = neg1 ^ neg2;
        rneg_d  = neg1;
        spec_d  = div0 | ovf;
        cnt_d   = '0;
        b_d     = mag2;
        acc_d   = (div0 | ovf) ? {{XLEN{1'b0}}, spec_val} : {{XLEN{1'b0}}, mag1};
        state_d = (div0 | ovf) ? DONE : BUSY;
      end
      BUSY: begin
        acc_d   = op_q[2] ? div_nxt : mul_nxt;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(XLEN-1)) ? DONE : BUSY;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      spec_q  <= spec_d;
    end
  end
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// tb_muldiv_seq_ctrl: directed self-checking bench for muldiv_seq_ctrl
module tb_muldiv_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        stall, out_valid;
  logic [31:0] result;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_done = 0;
  int          prev_done = 0;
  int          hits;

  muldiv_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .stall(stall), .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // present an op at a falling edge (cycle 0) and wait for its out_valid pulse
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    int st;
    in_valid = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    #1;
    check({tag, "_stall0"}, {31'd0, stall}, 32'd1);
    st = 1;
    k  = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
      if (stall) st++;
    end
    check({tag, "_lat"}, k, lat);
    check({tag, "_res"}, result, exp);
    check({tag, "_stalln"}, st, lat);
    prev_done = last_done;
    last_done = cyc;
    in_valid  = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mul", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    @(negedge clk);
    run_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    @(negedge clk);
    run_op("mulhu", 3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    @(negedge clk);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    @(negedge clk);
    run_op("mulu_big", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    @(negedge clk);
    run_op("div0", 3'b100, 32'h64, 32'h0, 32'hFFFFFFFF, 1);
    @(negedge clk);
    run_op("divu0", 3'b101, 32'h64, 32'h0, 32'hFFFFFFFF, 1);
    @(negedge clk);
    run_op("remu0", 3'b111, 32'h64, 32'h0, 32'h64, 1);
    @(negedge clk);
    run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    @(negedge clk);
    run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
    @(negedge clk);
    run_op("divu_noovf", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33);
    @(negedge clk);
    run_op("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    @(negedge clk);
    run_op("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    @(negedge clk);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    @(negedge clk);
    run_op("div_pn", 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
    @(negedge clk);
    // flush a DIVU at cycle 10, then the next op is accepted right after
    in_valid = 1'b1;
    funct3   = 3'b101;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    hits = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    flush = 1'b1;
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    if (out_valid) hits++;
    flush = 1'b0;
    check("flush_noov", hits, 0);
    run_op("after_flush", 3'b100, 32'hFFFFFC18, 32'd3, 32'hFFFFFEB3, 33);
    @(negedge clk);
    // async reset mid-MUL, then a back-to-back MUL,DIV pair
    in_valid = 1'b1;
    funct3   = 3'b000;
    rs1_data = 32'd12345;
    rs2_data = 32'd678;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_ov", {31'd0, out_valid}, 32'd0);
    check("rstmid_res", result, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("pair_mul", 3'b000, 32'd12345, 32'd678, 32'd8369910, 33);
    @(negedge clk);
    run_op("pair_div", 3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);
    check("pair_gap", last_done - prev_done, 34);
    @(negedge clk);
    check("idle_ov", {31'd0, out_valid}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
